// File: rtl/hex_display_pkg.sv
// Shared constants and helpers for the hex seven-segment display controller.
// Segment vectors are active-low in gfedcba order: bit 6 = g, bit 0 = a.
package hex_display_pkg;

  // All segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low patterns for hex digits 0..F, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Nibble to active-low segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

  // Bits needed to count 0..n-1; at least one bit so degenerate
  // dividers (n == 1) still give a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_seg_lut.sv
// Combinational decode of one hex nibble to active-low segments, with a
// visibility gate that forces the digit dark.
module hex_seg_lut
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       visible,
  output logic [6:0] seg
);

  assign seg = visible ? hex_to_seg(nibble) : SEG_BLANK;

endmodule

// File: rtl/hex_display_ctrl.sv
// N-digit hex seven-segment controller. Latches a packed hex value on load
// and drives it both as static per-digit segments (seg_all) and as a
// time-multiplexed segment bus with active-low digit select (seg_mux,
// dig_sel). Leading-zero suppression, per-digit blink and whole-display
// blanking are applied before the outputs are registered.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [4*DIGITS-1:0]   shown,
  output logic [7*DIGITS-1:0]   seg_all,
  output logic [6:0]            seg_mux,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int unsigned SCAN_W  = cnt_width(SCAN_DIV);
  localparam int unsigned BLINK_W = cnt_width(BLINK_DIV);
  localparam int unsigned IDX_W   = cnt_width(DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);

  // Timebase state.
  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;   // 1 = blinking digits dark

  // Per-digit decode path.
  logic [DIGITS-1:0]  nz_suffix;     // bit i: some nibble in i..DIGITS-1 is non-zero
  logic [DIGITS-1:0]  visible;
  logic [6:0]         seg_dig [DIGITS];

  // Next-state values for the registered outputs.
  logic [7*DIGITS-1:0] seg_all_next;
  logic [6:0]          seg_mux_next;
  logic [DIGITS-1:0]   dig_sel_next;

  // ---------------------------------------------------------------------
  // Leading-zero detection: an OR chain from the most significant nibble
  // downwards, so nz_suffix[i] tells whether digit i or anything above it
  // carries a non-zero nibble.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < DIGITS; i++) begin : g_nz
    if (i == DIGITS - 1) begin : g_top
      assign nz_suffix[i] = |shown[4*i +: 4];
    end else begin : g_chain
      assign nz_suffix[i] = (|shown[4*i +: 4]) | nz_suffix[i+1];
    end
  end

  // ---------------------------------------------------------------------
  // Visibility and segment decode per digit. Digit 0 is never
  // zero-suppressed so an all-zero value still shows a single "0".
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign visible[i] = !blank && !(blink_phase && blink_mask[i]);
    end else begin : g_upper
      assign visible[i] = !blank
                        && !(blink_phase && blink_mask[i])
                        && !(lz_en && !nz_suffix[i]);
    end

    hex_seg_lut u_lut (
      .nibble  (shown[4*i +: 4]),
      .visible (visible[i]),
      .seg     (seg_dig[i])
    );

    assign seg_all_next[7*i +: 7] = seg_dig[i];
  end

  // Select the scanned digit's already-gated segments and its select line.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loop leaves a value unassigned and no latch is inferred.
    seg_mux_next = SEG_BLANK;
    dig_sel_next = '1;
    if (!blank) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (scan_idx == IDX_W'(i)) begin
          seg_mux_next    = seg_dig[i];
          dig_sel_next[i] = 1'b0;
        end
      end
    end
  end

  // Latch the displayed value; load wins regardless of blank.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: state is updated with <= so every register samples the values
    // from before this edge; shown therefore feeds the segment registers
    // one cycle later.
    if (clr) begin
      shown <= '0;
    end else if (load) begin
      shown <= value;
    end
  end

  // Scan timebase: hold each digit for SCAN_DIV cycles, then move on.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Blink timebase: free-running, toggles the phase every BLINK_DIV cycles.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Register all display outputs together so seg_mux and dig_sel always
  // describe the same digit.
  always_ff @(posedge clk or posedge clr) begin
    // NOTE: every output register has an explicit reset value so the
    // display is dark from the moment clr asserts, with no clock needed.
    if (clr) begin
      seg_all <= '1;
      seg_mux <= SEG_BLANK;
      dig_sel <= '1;
    end else begin
      seg_all <= seg_all_next;
      seg_mux <= seg_mux_next;
      dig_sel <= dig_sel_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl. The driver pushes the predicted
// post-edge outputs for every clock; a monitor pops and compares them just
// after each rising edge. Prediction is made from elapsed-cycle arithmetic
// and a plain decode table.
module tb_hex_display_ctrl;

  localparam int D = 2;
  localparam int S = 4;
  localparam int B = 8;

  typedef logic [4*D-1:0] val_t;
  typedef logic [D-1:0]   mask_t;

  typedef struct packed {
    logic [4*D-1:0] shown;
    logic [7*D-1:0] seg_all;
    logic [6:0]     seg_mux;
    logic [D-1:0]   dig_sel;
  } exp_t;

  logic           clk = 1'b0;
  logic           clr = 1'b0;
  logic           load = 1'b0;
  val_t           value = '0;
  logic           blank = 1'b0;
  logic           lz_en = 1'b0;
  mask_t          blink_mask = '0;
  logic [4*D-1:0] shown;
  logic [7*D-1:0] seg_all;
  logic [6:0]     seg_mux;
  logic [D-1:0]   dig_sel;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: edges since reset release, and the held value.
  int   k_m = 0;
  val_t shown_m = '0;
  int   last_idx = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk        (clk),
    .clr        (clr),
    .load       (load),
    .value      (value),
    .blank      (blank),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .shown      (shown),
    .seg_all    (seg_all),
    .seg_mux    (seg_mux),
    .dig_sel    (dig_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Outputs after an edge, given the value held and cycle count before it.
  function automatic exp_t predict(input val_t sh, input logic bl, input logic lz,
                                   input mask_t mk, input int k);
    exp_t e;
    int   idx;
    int   phase;
    logic vis;
    idx   = (k / S) % D;
    phase = (k / B) % 2;
    e = '0;
    for (int i = 0; i < D; i++) begin
      vis = !bl;
      if (phase == 1 && mk[i]) vis = 1'b0;
      if (lz && i > 0 && (sh >> (4*i)) == 0) vis = 1'b0;
      e.seg_all[7*i +: 7] = vis ? tbl[sh[4*i +: 4]] : 7'h7F;
    end
    e.seg_mux = bl ? 7'h7F : e.seg_all[7*idx +: 7];
    e.dig_sel = bl ? '1 : ~(mask_t'(1) << idx);
    return e;
  endfunction

  // Drive one cycle of inputs and queue the expected post-edge outputs.
  task automatic step(input logic ld, input val_t val, input logic bl, input logic lz,
                      input mask_t mk, input logic rst = 1'b0);
    exp_t e;
    @(negedge clk);
    clr = rst; load = ld; value = val; blank = bl; lz_en = lz; blink_mask = mk;
    if (rst) begin
      k_m = 0;
      shown_m = '0;
      e.shown = '0; e.seg_all = '1; e.seg_mux = 7'h7F; e.dig_sel = '1;
    end else begin
      e = predict(shown_m, bl, lz, mk, k_m);
      last_idx = (k_m / S) % D;
      if (ld) shown_m = val;
      e.shown = shown_m;
      k_m++;
    end
    sb.push_back(e);
  endtask

  task automatic check_dark(input string tag);
    check({tag, ".shown"},   32'(shown),   32'h0);
    check({tag, ".seg_all"}, 32'(seg_all), 32'h3FFF);
    check({tag, ".seg_mux"}, 32'(seg_mux), 32'h7F);
    check({tag, ".dig_sel"}, 32'(dig_sel), 32'h3);
  endtask

  // Monitor: compare DUT outputs against the queued prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("shown",   32'(shown),   32'(e.shown));
        check("seg_all", 32'(seg_all), 32'(e.seg_all));
        check("seg_mux", 32'(seg_mux), 32'(e.seg_mux));
        check("dig_sel", 32'(dig_sel), 32'(e.dig_sel));
      end
    end
  end

  initial begin
    int guard;
    // Asynchronous reset before any clock edge.
    #1 clr = 1'b1;
    #1 check_dark("reset_async");
    step(0, '0, 0, 0, '0, 1);
    step(0, '0, 0, 0, '0, 1);

    // Release, then load-latency check with A5.
    step(0, '0, 0, 0, '0);
    step(0, '0, 0, 0, '0);
    step(1, 8'hA5, 0, 0, '0);
    repeat (3) step(0, '0, 0, 0, '0);

    // Leading-zero suppression.
    step(1, 8'h07, 0, 1, '0);
    repeat (2) step(0, '0, 0, 1, '0);
    step(1, 8'h00, 0, 1, '0);
    repeat (2) step(0, '0, 0, 1, '0);
    repeat (2) step(0, '0, 0, 0, '0);

    // Scan sweep over 3C.
    step(1, 8'h3C, 0, 0, '0);
    repeat (16) step(0, '0, 0, 0, '0);

    // Blink digit 0 over several half-periods.
    repeat (34) step(0, '0, 0, 0, 2'b01);

    // Blank, with a load while blanked.
    repeat (3) step(0, '0, 1, 0, '0);
    step(1, 8'h5E, 1, 0, '0);
    repeat (3) step(0, '0, 1, 0, '0);
    repeat (3) step(0, '0, 0, 1, 2'b10);

    // Reset mid-scan: run until digit 1 is being scanned, then assert clr.
    guard = 0;
    do begin
      step(0, '0, 0, 0, '0);
      guard++;
    end while (last_idx != 1 && guard < 20);
    check("find_idx1", 32'(last_idx), 32'd1);
    @(posedge clk);
    #3 clr = 1'b1;
    #1 check_dark("reset_mid");
    step(0, '0, 0, 0, '0, 1);
    step(0, '0, 0, 0, '0, 1);
    repeat (4) step(0, '0, 0, 0, 2'b11);

    // Randomized traffic with occasional resets.
    repeat (400) begin
      step($urandom_range(0, 3) == 0, val_t'($urandom), $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)), mask_t'($urandom), $urandom_range(0, 99) == 0);
    end
    step(0, '0, 0, 0, '0);

    repeat (3) @(posedge clk);
    #2 check("drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
